// File: rtl/adder_pkg.sv
// Shared types for the byte-serial add/subtract sequencer.
package adder_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/byte_serial_adder_add8.sv
// 8-bit ripple-carry adder used as the single shared byte datapath.
module add8
    import adder_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_ci,
    output logic [BYTE_W-1:0] o_s,
    output logic              o_co
);
    logic [BYTE_W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{BYTE_W{1'b0}}, i_ci};
    assign o_s    = w_full[BYTE_W-1:0];
    assign o_co   = w_full[BYTE_W];
endmodule

// File: rtl/byte_serial_adder.sv
// Multi-precision add/subtract: one byte per cycle through a shared add8,
// LSB first, with the carry held in a register between cycles.
module byte_serial_adder
    import adder_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);
    localparam int W    = BYTE_W * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;

    logic [IDXW+2:0]   w_off;
    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W-1:0] w_s;
    logic              w_co;
    logic              w_last;

    assign w_off    = {r_idx, 3'b000};
    assign w_a_byte = r_a[w_off +: BYTE_W];
    assign w_b_byte = r_b[w_off +: BYTE_W] ^ {BYTE_W{r_sub}};
    assign w_last   = (r_idx == LAST);

    add8 u_add8 (
        .i_a  (w_a_byte),
        .i_b  (w_b_byte),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= sub;
                        r_carry <= sub | cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[w_off +: BYTE_W] <= w_s;
                    r_carry                <= w_co;
                    // idx parks on the last byte instead of wrapping
                    if (w_last) begin
                        r_cout <= w_co;
                        r_ovf  <= (w_a_byte[BYTE_W-1] == w_b_byte[BYTE_W-1]) &&
                                  (w_s[BYTE_W-1] != w_a_byte[BYTE_W-1]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed self-checking bench for byte_serial_adder (NBYTES=4).
module tb_byte_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    byte_serial_adder #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Drive one operand beat at a negedge and count negedges until out_valid.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tcin, input logic tsub, output int lat);
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; sub = tsub;
        in_valid = 1'b1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_release();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b ov=%b want 0", sum, cout, ovf, out_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_carry();
        int lat;
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL carry_latency: got %0d want 5", lat);
        end
        checks++;
        if (sum !== 32'h00000100 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL carry_result: sum=%h c=%b o=%b want 00000100 0 0", sum, cout, ovf);
        end
        do_release();
    endtask

    task automatic test_wrap();
        int lat;
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 5 || sum !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL wrap_b1: lat=%0d sum=%h c=%b o=%b want 5 00000000 1 0", lat, sum, cout, ovf);
        end
        do_release();
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 5 || sum !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL wrap_cin: lat=%0d sum=%h c=%b o=%b want 5 00000000 1 0", lat, sum, cout, ovf);
        end
        do_release();
    endtask

    task automatic test_sub();
        int lat;
        do_op(32'd5, 32'd7, 1'b1, 1'b1, lat);
        checks++;
        if (lat !== 5 || sum !== 32'hFFFFFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_borrow: lat=%0d sum=%h c=%b o=%b want 5 fffffffe 0 0", lat, sum, cout, ovf);
        end
        do_release();
        do_op(32'd7, 32'd5, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== 5 || sum !== 32'd2 || cout !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_noborrow: lat=%0d sum=%h c=%b o=%b want 5 00000002 1 0", lat, sum, cout, ovf);
        end
        do_release();
    endtask

    task automatic test_ovf();
        int lat;
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 5 || sum !== 32'h80000000 || cout !== 1'b0 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_add: lat=%0d sum=%h c=%b o=%b want 5 80000000 0 1", lat, sum, cout, ovf);
        end
        do_release();
        do_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== 5 || sum !== 32'h7FFFFFFF || cout !== 1'b1 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sub: lat=%0d sum=%h c=%b o=%b want 5 7fffffff 1 1", lat, sum, cout, ovf);
        end
        do_release();
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        a = 32'h00000003; b = 32'h00000004; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        // stray beat held through RUN and DONE must be ignored
        a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1;
        lat = -1;
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 5 || sum !== 32'h00000007 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL bp_result: lat=%0d sum=%h c=%b o=%b want 5 00000007 0 0", lat, sum, cout, ovf);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h00000007 ||
                cout !== 1'b0 || ovf !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b sum=%h c=%b o=%b want 1 0 00000007 0 0",
                         i, out_valid, in_ready, sum, cout, ovf);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: sum=%h c=%b o=%b ov=%b want 0", sum, cout, ovf, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL midrun_idle%0d: ov=%b ir=%b want 0 1", i, out_valid, in_ready);
            end
        end
        do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 5 || sum !== 32'h23456789 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL midrun_next: lat=%0d sum=%h c=%b o=%b want 5 23456789 0 0", lat, sum, cout, ovf);
        end
        do_release();
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap();
        test_sub();
        test_ovf();
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_serial_adder.md
# byte_serial_adder

Multi-precision add/subtract sequencer that computes NBYTES-wide results by time-multiplexing the existing 8-bit ripple-carry adder (`add8`), one byte per cycle, least-significant byte first. The carry is held in a register between cycles. It sits between an operand producer and a result consumer, with a valid/ready handshake on both sides. It is the standard way to get wide arithmetic in the design without instantiating wide adders.

## Interface
- NBYTES, 4, operand/result width in bytes; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  8*NBYTES  operand A.
- b  input  8*NBYTES  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1 = compute A − B (B inverted, carry-in forced to 1).
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- sum  output  8*NBYTES  result.
- cout  output  1  final carry-out; for sub, 1 = no borrow.
- ovf  output  1  signed overflow of the full-width result.

## Operation
- States: IDLE, RUN, DONE. The state encoding lives in the package.
- IDLE:
  - in_ready=1.
  - On in_valid: register a, b, sub; set carry_q = sub ? 1 : cin; set idx=0; go to RUN.
- RUN, one byte per cycle:
  - add8 inputs: a_q[idx], b_q[idx] ^ {8{sub_q}}, carry_q.
  - sum_q[idx] <= add8 out; carry_q <= add8 cout; idx <= idx+1.
  - On the cycle with idx==NBYTES-1: latch cout from the final carry and compute ovf, then go to DONE.
- ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is B after the optional inversion.
- DONE:
  - out_valid=1; sum, cout and ovf stay stable.
  - On out_ready: go to IDLE. The next operand is accepted no earlier than the following cycle.
- sum bytes not yet written in the current operation keep their previous values. Only the DONE state qualifies sum.
- in_valid outside IDLE is ignored; operands are not latched.
- Asynchronous reset from any state, including mid-RUN:
  - state=IDLE, idx=0, carry_q=0;
  - sum=0, cout=0, ovf=0, out_valid=0;
  - in_ready=1 once rst deasserts.
  - The aborted operation is discarded and never produces out_valid.
- All arithmetic is unsigned modulo 2^(8*NBYTES). idx has width clog2(NBYTES) and never wraps past NBYTES-1.

## Timing
- in_ready and out_valid are decoded directly from the state register; there is no combinational path from inputs to outputs.
- Accept edge at T0 (in_valid && in_ready). RUN occupies T0+1 .. T0+NBYTES. out_valid rises at T0+NBYTES+1.
- Latency is NBYTES+1 cycles; 5 for NBYTES=4.
- Minimum initiation interval is NBYTES+2 cycles: accept, NBYTES RUN cycles, one DONE cycle with out_ready=1, then the next accept.
- Backpressure: DONE holds indefinitely while out_ready=0, and in_ready stays 0.
- The add8 critical path is one 8-bit ripple plus the carry register, per cycle.

## Structure
- Package `adder_pkg`: state enum (IDLE/RUN/DONE) and a BYTE_W=8 constant.
- One sub-module: a single `add8` instance as the shared byte datapath.
- Byte select and write-back are done with indexed part-selects; there is no second adder.
- The controller (FSM, idx counter, carry register) stays in this module.

## Test plan
- Carry propagation: A=0x000000FF, B=0x00000001, cin=0, sub=0 -> sum=0x00000100, cout=0, ovf=0, out_valid exactly 5 cycles after accept.
- Full wrap: A=0xFFFFFFFF, B=0x00000001 -> sum=0x00000000, cout=1, ovf=0. Same operands with cin=1 and B=0 -> same result.
- Subtract with borrow: A=5, B=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. A=7, B=5, sub=1 -> sum=2, cout=1.
- Signed overflow: A=0x7FFFFFFF + B=1 -> sum=0x80000000, ovf=1. A=0x80000000 − B=1 (sub) -> sum=0x7FFFFFFF, ovf=1.
- Backpressure and ignored input:
  - Hold out_ready=0 for 10 cycles in DONE -> sum/cout/ovf stable, in_ready=0, and an in_valid pulse during RUN/DONE is not captured.
  - Then out_ready=1 -> IDLE on the next cycle.
- Reset mid-RUN: assert rst at idx=2 -> outputs are 0 immediately and in_ready=1 after release. A following 0x12345678+0x11111111 yields 0x23456789 with no stale carry.
